// File: rtl/sample_player_if.sv
// Read-port bundle between the sample player and the cellular-RAM controller.
// The player is the master: it raises mem_req with a stable mem_addr. The RAM
// controller answers with a one-cycle mem_ack that carries mem_data.
interface sample_player_if #(
    parameter int ADDR_W = 23
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/sample_player.sv
// Streams 16-bit signed PCM words from external RAM into a small FIFO.
// Samples are released at a fixed tick rate, and the current sample drives a
// first-order delta-sigma modulator that produces a 1-bit audio output.
module sample_player #(
    parameter int ADDR_W     = 23,
    parameter int SAMPLE_DIV = 2267,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,          // synchronous, active-low
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    sample_player_if.master   mem,
    output logic [15:0]       sample_out,
    output logic              audio_sd,
    output logic              playing,
    output logic              underrun
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_PLAY    = 2'd2,
        S_ABORT   = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remaining_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] length_q;
    logic              loop_q;
    logic              req_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [15:0]       sample_q;
    logic              underrun_q;
    logic [16:0]       acc_q;

    logic [15:0]       fifo_mem [FIFO_DEPTH];

    logic              active;
    logic              tick;
    logic              push;
    logic              pop;
    logic              fetch_done;

    // Strobes shared by the FSM and the FIFO storage
    always_comb begin
        active     = (state_q == S_PREFILL) || (state_q == S_PLAY);
        fetch_done = (remaining_q == '0);
        tick       = (state_q == S_PLAY) && (cnt_q == CNT_LAST);
        push       = active && !stop && req_q && mem.mem_ack;
        pop        = tick && !stop && (count_q != '0);
    end

    // Playback FSM with fetch engine, FIFO bookkeeping and tick counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            base_q      <= '0;
            length_q    <= '0;
            loop_q      <= 1'b0;
            req_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            sample_q    <= '0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start && !stop && (length != '0)) begin
                        addr_q      <= base_addr;
                        remaining_q <= length;
                        base_q      <= base_addr;
                        length_q    <= length;
                        loop_q      <= loop;
                        state_q     <= S_PREFILL;
                    end
                end

                S_ABORT: begin
                    // Outstanding read must complete; its data is dropped.
                    if (mem.mem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin  // S_PREFILL, S_PLAY
                    if (stop) begin
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        count_q  <= '0;
                        cnt_q    <= '0;
                        sample_q <= '0;
                        if (req_q && !mem.mem_ack) begin
                            state_q <= S_ABORT;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        // Fetch: one outstanding read, issued only with FIFO room.
                        if (req_q) begin
                            if (mem.mem_ack) begin
                                req_q <= 1'b0;
                                if (remaining_q == ADDR_W'(1)) begin
                                    if (loop_q) begin
                                        addr_q      <= base_q;
                                        remaining_q <= length_q;
                                    end else begin
                                        addr_q      <= addr_q + ADDR_W'(1);
                                        remaining_q <= '0;
                                    end
                                end else begin
                                    addr_q      <= addr_q + ADDR_W'(1);
                                    remaining_q <= remaining_q - ADDR_W'(1);
                                end
                            end
                        end else if ((count_q < DEPTH_C) && !fetch_done) begin
                            req_q <= 1'b1;
                        end

                        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                        case ({push, pop})
                            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                            default: count_q <= count_q;
                        endcase

                        if (state_q == S_PREFILL) begin
                            cnt_q <= '0;
                            if ((count_q == DEPTH_C) || fetch_done) begin
                                state_q <= S_PLAY;
                            end
                        end else if (tick) begin
                            cnt_q <= '0;
                            if (count_q != '0) begin
                                sample_q <= fifo_mem[rd_ptr_q];
                            end else if (!fetch_done) begin
                                underrun_q <= 1'b1;
                            end else begin
                                sample_q <= '0;
                                state_q  <= S_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Sample FIFO storage; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem.mem_data;
        end
    end

    // First-order delta-sigma: carry out of the offset-binary accumulator
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= {1'b0, acc_q[15:0]} + {1'b0, sample_q ^ 16'h8000};
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign sample_out   = sample_q;
    assign audio_sd     = acc_q[16];
    assign playing      = (state_q != S_IDLE);
    assign underrun     = underrun_q;
endmodule
